flex_lane_fifo: RTL and testbench

FLEX_LANE_FIFO -- requirements
Module: flex_lane_fifo

---
 rtl/flex_lane_fifo.sv | 96 +++++++++
 tb/tb_flex_lane_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/flex_lane_fifo.sv
// Multi-lane FIFO: up to LANES elements pushed and popped per cycle, with a
// first-word-fall-through head window, occupancy thresholds and sticky error flags.
module flex_lane_fifo #(
  parameter int DEPTH     = 16,
  parameter int LANES     = 4,
  parameter int DW        = 32,
  parameter int AFULL_TH  = DEPTH - LANES,
  parameter int AEMPTY_TH = LANES
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic [$clog2(LANES):0]     push_cnt,
  input  logic [LANES*DW-1:0]        dat_in,
  input  logic [$clog2(LANES):0]     pop_cnt,
  output logic [LANES*DW-1:0]        dat_out,
  output logic [LANES-1:0]           out_vld,
  output logic [$clog2(DEPTH):0]     ocp,
  output logic                       is_full,
  output logic                       is_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       push_ok,
  output logic                       pop_ok,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = $clog2(LANES) + 1;

  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [OW-1:0] AF_O    = OW'(AFULL_TH);
  localparam logic [OW-1:0] AE_O    = OW'(AEMPTY_TH);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  logic [DW-1:0]  mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [OW-1:0]  free_cnt;
  logic [OW-1:0]  push_add;
  logic [OW-1:0]  pop_sub;

  // Free space is taken before this cycle's pop, so a full FIFO never accepts
  // a push even when a pop is draining it in the same cycle.
  assign free_cnt = DEPTH_O - ocp;
  assign push_ok  = !flush && (push_cnt <= LANES_C) && (OW'(push_cnt) <= free_cnt);
  assign pop_ok   = !flush && (pop_cnt <= LANES_C) && (OW'(pop_cnt) <= ocp);
  assign push_add = push_ok ? OW'(push_cnt) : '0;
  assign pop_sub  = pop_ok  ? OW'(pop_cnt)  : '0;

  assign is_full      = (ocp == DEPTH_O);
  assign is_empty     = (ocp == '0);
  assign almost_full  = (ocp >= AF_O);
  assign almost_empty = (ocp <= AE_O);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its peers; blocking here would create order races.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ocp     <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push_add);
      rd_ptr  <= rd_ptr + PW'(pop_sub);
      ocp     <= ocp + push_add - pop_sub;
      ovf_err <= ovf_err | ((push_cnt != '0) && !push_ok);
      udf_err <= udf_err | ((pop_cnt  != '0) && !pop_ok);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; occupancy and
  // pointers define validity, and a resettable array costs a flop per bit.
  always_ff @(posedge CLK) begin
    for (int j = 0; j < LANES; j++) begin
      if (!RST && push_ok && (j < int'(push_cnt)))
        mem[wr_ptr + PW'(j)] <= dat_in[j*DW +: DW];
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dat_out = '0;
    out_vld = '0;
    for (int i = 0; i < LANES; i++) begin
      dat_out[i*DW +: DW] = mem[rd_ptr + PW'(i)];
      out_vld[i]          = (ocp > OW'(i));
    end
  end

endmodule

// File: tb/tb_flex_lane_fifo.sv
// Scoreboard bench for flex_lane_fifo (DEPTH=8, LANES=4, DW=32): a queue-based
// reference model predicts each cycle's outputs, and a negedge monitor compares them.
module tb_flex_lane_fifo;

  localparam int DEPTH = 8;
  localparam int LANES = 4;
  localparam int DW    = 32;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  flush = 1'b0;
  logic [2:0]            push_cnt = '0;
  logic [LANES*DW-1:0]   dat_in = '0;
  logic [2:0]            pop_cnt = '0;
  logic [LANES*DW-1:0]   dat_out;
  logic [LANES-1:0]      out_vld;
  logic [3:0]            ocp;
  logic                  is_full, is_empty, almost_full, almost_empty;
  logic                  push_ok, pop_ok, ovf_err, udf_err;

  flex_lane_fifo #(.DEPTH(DEPTH), .LANES(LANES), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .push_cnt(push_cnt), .dat_in(dat_in), .pop_cnt(pop_cnt),
    .dat_out(dat_out), .out_vld(out_vld), .ocp(ocp),
    .is_full(is_full), .is_empty(is_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .push_ok(push_ok), .pop_ok(pop_ok),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                  occ;
    bit                  pok;
    bit                  qok;
    bit                  ovf;
    bit                  udf;
    int                  nv;
    logic [LANES*DW-1:0] heads;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  bit          ovf_m = 1'b0;
  bit          udf_m = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, record the expected response of this
  // cycle, then advance the model to the state the next edge should produce.
  task automatic step(input bit rst, input bit fl, input int pc, input int oc);
    logic [LANES*DW-1:0] d;
    exp_t e;
    int   n;
    @(posedge CLK);
    #1;
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = $urandom;
    RST      = rst;
    flush    = fl;
    push_cnt = 3'(pc);
    pop_cnt  = 3'(oc);
    dat_in   = d;

    n       = mq.size();
    e.occ   = n;
    e.pok   = !fl && (pc <= LANES) && (pc <= DEPTH - n);
    e.qok   = !fl && (oc <= LANES) && (oc <= n);
    e.ovf   = ovf_m;
    e.udf   = udf_m;
    e.nv    = (n < LANES) ? n : LANES;
    e.heads = '0;
    for (int i = 0; i < e.nv; i++) e.heads[i*DW +: DW] = mq[i];
    exp_q.push_back(e);

    if (rst || fl) begin
      mq.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      if (pc > 0 && !e.pok) ovf_m = 1'b1;
      if (oc > 0 && !e.qok) udf_m = 1'b1;
      if (e.qok) for (int i = 0; i < oc; i++) void'(mq.pop_front());
      if (e.pok) for (int i = 0; i < pc; i++) mq.push_back(d[i*DW +: DW]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ocp",          64'(ocp),          64'(e.occ));
        check("push_ok",      64'(push_ok),      64'(e.pok));
        check("pop_ok",       64'(pop_ok),       64'(e.qok));
        check("ovf_err",      64'(ovf_err),      64'(e.ovf));
        check("udf_err",      64'(udf_err),      64'(e.udf));
        check("is_full",      64'(is_full),      64'(e.occ == DEPTH));
        check("is_empty",     64'(is_empty),     64'(e.occ == 0));
        check("almost_full",  64'(almost_full),  64'(e.occ >= DEPTH - LANES));
        check("almost_empty", 64'(almost_empty), 64'(e.occ <= LANES));
        check("out_vld",      64'(out_vld),      64'((1 << e.nv) - 1));
        for (int i = 0; i < LANES; i++)
          if (i < e.nv)
            check($sformatf("dat_out[%0d]", i), 64'(dat_out[i*DW +: DW]),
                  64'(e.heads[i*DW +: DW]));
      end
    end
  end

  initial begin : driver
    // Reset state, then a three-element push that must fall through next cycle.
    step(1, 0, 0, 0);
    step(0, 0, 3, 0);
    step(0, 0, 0, 0);
    // Overflow at ocp=6, then rejected push alongside an accepted pop.
    step(0, 0, 3, 0);
    step(0, 0, 3, 0);
    step(0, 0, 3, 2);
    step(0, 0, 0, 0);
    // Underflow at ocp=2, then an empty pop_cnt=0 that must not flag.
    step(0, 1, 0, 0);
    step(0, 0, 2, 0);
    step(0, 0, 0, 3);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Pointer wrap: bring both pointers to 6, push 4, pop 4.
    step(0, 0, 4, 0);
    step(0, 0, 0, 4);
    step(0, 0, 2, 0);
    step(0, 0, 0, 2);
    step(0, 0, 4, 0);
    step(0, 0, 0, 4);
    step(0, 0, 0, 0);
    // Flush overrides simultaneous push and pop at ocp=5.
    step(0, 0, 4, 0);
    step(0, 0, 1, 0);
    step(0, 1, 2, 1);
    step(0, 0, 0, 0);
    // Threshold crossings, fill to full, then reset mid-stream.
    step(0, 0, 3, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 3, 0);
    step(0, 0, 4, 0);
    step(1, 0, 2, 1);
    step(0, 0, 2, 0);
    step(0, 0, 0, 0);
    // Randomised traffic, including out-of-range counts, flushes and resets.
    for (int k = 0; k < 3000; k++) begin
      int r, pc, oc;
      r  = $urandom_range(0, 199);
      pc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      oc = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      step(r == 0, (r >= 1) && (r <= 4), pc, oc);
    end
    step(0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
